xcorr_fft_sched: RTL and testbench
==================================

// Module: xcorr_fft_sched
// PURPOSE
//  Frame-level scheduler sharing one streaming FFT correlator core between two requesters:
//  A = forward FFT of received I/Q, B = inverse FFT of the spectral product.
//  Arbitrates whole frames, drives the core's data and config inputs, and tags in-flight frames.
//  Routes each core output frame back to the requester that issued it.
// PARAMETERS
//  LOG2_N      10     log2 of FFT length; frame = 2**LOG2_N samples
//  TAG_DEPTH   4      max in-flight frames (tag FIFO depth, power of 2)
//  SCALE_FWD   7'h2A  scaling schedule for A frames, conf[7:1]
//  SCALE_INV   7'h2A  scaling schedule for B frames, conf[7:1]
// PORTS
//  clk        in   1   single clock
//  rst        in   1   asynchronous, active-high reset
//  a_val      in   1   A sample valid;  a_rdy out 1: A sample accepted when a_val & a_rdy
//  a_i, a_q   in   12  A sample, signed
//  b_val      in   1   B sample valid;  b_rdy out 1: B sample accepted when b_val & b_rdy
//  b_i, b_q   in   12  B sample, signed
//  fft_ival   out  1   to core data valid
//  fft_i/_q   out  12  to core data, signed
//  fft_conf   out  8   to core config: bit0 = 1 forward / 0 inverse, [7:1] scaling
//  fft_oval   in   1   from core output valid;  fft_oeop in 1: last sample of output frame
//  fft_oi/_oq in   12  from core output data;   fft_oexp in 8: block exponent
//  oa_val, ob_val out 1 routed output valid; oa_eop, ob_eop out 1: routed frame end
//  o_i, o_q   out  12  routed data (shared bus, qualified by oa_val/ob_val)
//  o_exp      out  8   exponent of the routed frame
//  err_orphan out  1   sticky: core output arrived with empty tag FIFO
// BEHAVIOUR
//  FSM IDLE -> CFG -> STREAM -> IDLE.
//  IDLE: grant when (a_val|b_val) and tag FIFO not full; equal requests -> round-robin,
//   priority to requester not served last; after reset A has priority.
//  CFG (1 cycle): latch grant, drive fft_conf (A: {SCALE_FWD,1}, B: {SCALE_INV,0}), push tag.
//  STREAM: granted rdy = 1, other rdy = 0; fft_ival = val & rdy, data registered (1-cycle latency).
//   Gaps (val low) allowed; sample counter counts accepted samples only; return to IDLE
//   after 2**LOG2_N accepted samples (counter wraps to 0). fft_conf held constant whole frame.
//  Output routing: combinational from fft_o* and head tag; oa/ob_val = fft_oval & tag match;
//   tag popped on fft_oval & fft_oeop. Push and pop same cycle: occupancy unchanged.
//  Empty FIFO while fft_oval: outputs suppressed, err_orphan set until rst.
//  rst (any time, incl. mid-frame): FSM IDLE, counter 0, FIFO empty, RR pointer -> A,
//   all outputs 0 (fft_conf = 8'h00, rdy = 0, err_orphan = 0). Partial frame is abandoned.
// CONFIGURATION
//  XCORR_EXP_ACC_EN defined: exponent of each A frame latched at oa_eop; o_exp during B frames
//   = B exponent + latched A exponent (8-bit, saturating at 8'hFF); latch cleared by rst.
//  Not defined: o_exp = fft_oexp unmodified for both requesters.
// STRUCTURE
//  Package xcorr_pkg: FSM state enum, tag enum (TAG_A, TAG_B), conf bit positions
//   (CONF_FWD_BIT = 0, CONF_SCALE_LSB = 1), sample/exponent widths.
//  Sub-module xcorr_tag_fifo: TAG_DEPTH x 1-bit FIFO, push/pop/full/empty, async reset.
// TESTING
//  Only A streams 1024 samples -> fft_conf = {SCALE_FWD,1} from CFG cycle, 1024 fft_ival, output
//   frame appears on oa_val only, oa_eop on sample 1024.
//  A and B both valid in IDLE after reset -> A frame first, then B; next simultaneous pair -> B first.
//  A deasserts val for 5 cycles mid-frame -> exactly 1024 accepted, frame ends on sample 1024.
//  4 frames issued with no core output -> FIFO full, rdy low, no new grant until one oeop.
//  fft_oval pulse with FIFO empty -> no oa/ob_val, err_orphan = 1 until rst.
//  rst asserted at sample 500 -> next cycle all outputs 0, FSM IDLE; with XCORR_EXP_ACC_EN,
//   A exp 3 then B exp 4 -> o_exp = 7 on B frame; A 8'hF0 + B 8'h20 -> 8'hFF.

Source files
------------

// File: rtl/xcorr_pkg.sv
// Shared types and constants for the FFT correlator frame scheduler.
package xcorr_pkg;

    localparam int unsigned SAMPLE_W       = 12;
    localparam int unsigned EXP_W          = 8;
    localparam int unsigned CONF_W         = 8;
    localparam int unsigned CONF_FWD_BIT   = 0;
    localparam int unsigned CONF_SCALE_LSB = 1;
    localparam int unsigned SCALE_W        = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CFG,
        ST_STREAM
    } state_t;

    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } tag_t;

    // Unsigned add clamped at all-ones.
    function automatic logic [EXP_W-1:0] sat_add(input logic [EXP_W-1:0] x,
                                                 input logic [EXP_W-1:0] y);
        logic [EXP_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[EXP_W] ? '1 : s[EXP_W-1:0];
    endfunction

endpackage

// File: rtl/xcorr_tag_fifo.sv
// Small FIFO of requester tags for frames in flight through the FFT core.
import xcorr_pkg::*;

module xcorr_tag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  tag_t din,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_t           mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    // Storage, pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= TAG_A;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) rptr <= rptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/xcorr_fft_sched.sv
// Frame scheduler sharing one streaming FFT core between requester A (forward)
// and requester B (inverse), routing core output frames back by tag.
// Optional feature macro: XCORR_EXP_ACC_EN (B-frame exponent accumulates the
// last A-frame exponent, saturating).
import xcorr_pkg::*;

module xcorr_fft_sched #(
    parameter int unsigned  LOG2_N    = 10,
    parameter int unsigned  TAG_DEPTH = 4,
    parameter logic [6:0]   SCALE_FWD = 7'h2A,
    parameter logic [6:0]   SCALE_INV = 7'h2A
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_val,
    output logic                a_rdy,
    input  logic [SAMPLE_W-1:0] a_i,
    input  logic [SAMPLE_W-1:0] a_q,
    input  logic                b_val,
    output logic                b_rdy,
    input  logic [SAMPLE_W-1:0] b_i,
    input  logic [SAMPLE_W-1:0] b_q,
    output logic                fft_ival,
    output logic [SAMPLE_W-1:0] fft_i,
    output logic [SAMPLE_W-1:0] fft_q,
    output logic [CONF_W-1:0]   fft_conf,
    input  logic                fft_oval,
    input  logic                fft_oeop,
    input  logic [SAMPLE_W-1:0] fft_oi,
    input  logic [SAMPLE_W-1:0] fft_oq,
    input  logic [EXP_W-1:0]    fft_oexp,
    output logic                oa_val,
    output logic                ob_val,
    output logic                oa_eop,
    output logic                ob_eop,
    output logic [SAMPLE_W-1:0] o_i,
    output logic [SAMPLE_W-1:0] o_q,
    output logic [EXP_W-1:0]    o_exp,
    output logic                err_orphan
);

    state_t             state;
    tag_t               gnt;
    logic               prio_b;
    logic [LOG2_N-1:0]  cnt;
    logic [CONF_W-1:0]  conf_a;
    logic [CONF_W-1:0]  conf_b;
    logic               pick_b;
    logic               acc_a;
    logic               acc_b;
    logic               tag_push;
    logic               tag_pop;
    tag_t               head;
    logic               tag_full;
    logic               tag_empty;
    logic               routed;

    // Per-requester core configuration words.
    always_comb begin
        conf_a = '0;
        conf_a[CONF_FWD_BIT] = 1'b1;
        conf_a[CONF_SCALE_LSB +: SCALE_W] = SCALE_FWD;
        conf_b = '0;
        conf_b[CONF_SCALE_LSB +: SCALE_W] = SCALE_INV;
    end

    assign pick_b   = b_val & (~a_val | prio_b);
    assign acc_a    = a_val & a_rdy;
    assign acc_b    = b_val & b_rdy;
    assign tag_push = (state == ST_CFG);
    assign tag_pop  = fft_oval & fft_oeop;

    // Frame FSM: the grant and config word are captured on the IDLE->CFG edge so
    // fft_conf is already valid during the CFG cycle, where the tag is pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= TAG_A;
            prio_b   <= 1'b0;
            cnt      <= '0;
            a_rdy    <= 1'b0;
            b_rdy    <= 1'b0;
            fft_conf <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((a_val || b_val) && !tag_full) begin
                        gnt      <= pick_b ? TAG_B : TAG_A;
                        prio_b   <= ~pick_b;
                        fft_conf <= pick_b ? conf_b : conf_a;
                        state    <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    a_rdy <= (gnt == TAG_A);
                    b_rdy <= (gnt == TAG_B);
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (acc_a || acc_b) begin
                        cnt <= cnt + LOG2_N'(1);
                        if (cnt == '1) begin
                            a_rdy <= 1'b0;
                            b_rdy <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Core input data path: one-cycle registered copy of the accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fft_ival <= 1'b0;
            fft_i    <= '0;
            fft_q    <= '0;
        end else begin
            fft_ival <= acc_a | acc_b;
            if (acc_a || acc_b) begin
                fft_i <= acc_b ? b_i : a_i;
                fft_q <= acc_b ? b_q : a_q;
            end
        end
    end

    xcorr_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (gnt),
        .head  (head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Output routing by head tag; nothing is routed without a tag.
    assign routed = fft_oval & ~tag_empty;
    assign oa_val = routed & (head == TAG_A);
    assign ob_val = routed & (head == TAG_B);
    assign oa_eop = oa_val & fft_oeop;
    assign ob_eop = ob_val & fft_oeop;
    assign o_i    = routed ? fft_oi : '0;
    assign o_q    = routed ? fft_oq : '0;

    // Sticky flag for core output arriving with no frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         err_orphan <= 1'b0;
        else if (fft_oval && tag_empty)  err_orphan <= 1'b1;
    end

`ifdef XCORR_EXP_ACC_EN
    logic [EXP_W-1:0] a_exp_lat;

    // Remember the exponent of the most recent A frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         a_exp_lat <= '0;
        else if (oa_eop) a_exp_lat <= fft_oexp;
    end

    assign o_exp = ob_val ? sat_add(fft_oexp, a_exp_lat) :
                   routed ? fft_oexp : '0;
`else
    assign o_exp = routed ? fft_oexp : '0;
`endif

endmodule

// File: tb/tb_xcorr_fft_sched.sv
// Directed bench for xcorr_fft_sched: arbitration, framing, FIFO full, routing,
// orphan detection, mid-frame reset and optional exponent accumulation.
module tb_xcorr_fft_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_val, a_rdy, b_val, b_rdy;
    logic [11:0] a_i, a_q, b_i, b_q;
    logic        fft_ival;
    logic [11:0] fft_i, fft_q;
    logic [7:0]  fft_conf;
    logic        fft_oval, fft_oeop;
    logic [11:0] fft_oi, fft_oq;
    logic [7:0]  fft_oexp;
    logic        oa_val, ob_val, oa_eop, ob_eop;
    logic [11:0] o_i, o_q;
    logic [7:0]  o_exp;
    logic        err_orphan;

    localparam logic [7:0] CONF_A = 8'h55;  // {7'h2A, 1}
    localparam logic [7:0] CONF_B = 8'h54;  // {7'h2A, 0}

    always #5 clk = ~clk;

    xcorr_fft_sched #(
        .LOG2_N    (10),
        .TAG_DEPTH (4),
        .SCALE_FWD (7'h2A),
        .SCALE_INV (7'h2A)
    ) dut (
        .clk(clk), .rst(rst),
        .a_val(a_val), .a_rdy(a_rdy), .a_i(a_i), .a_q(a_q),
        .b_val(b_val), .b_rdy(b_rdy), .b_i(b_i), .b_q(b_q),
        .fft_ival(fft_ival), .fft_i(fft_i), .fft_q(fft_q), .fft_conf(fft_conf),
        .fft_oval(fft_oval), .fft_oeop(fft_oeop), .fft_oi(fft_oi), .fft_oq(fft_oq),
        .fft_oexp(fft_oexp),
        .oa_val(oa_val), .ob_val(ob_val), .oa_eop(oa_eop), .ob_eop(ob_eop),
        .o_i(o_i), .o_q(o_q), .o_exp(o_exp), .err_orphan(err_orphan)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Core-input monitor: sample index n must appear as i=n, q=~n under a fixed conf.
    int         ival_cnt = 0;
    int         dat_err  = 0;
    int         conf_err = 0;
    logic [7:0] mon_conf = 8'h00;

    always @(negedge clk) begin
        if (fft_ival) begin
            if (fft_i !== 12'(ival_cnt) || fft_q !== ~12'(ival_cnt)) dat_err++;
            if (fft_conf !== mon_conf) conf_err++;
            ival_cnt++;
        end
    end

    function automatic logic rdy_of(input bit is_b);
        return is_b ? b_rdy : a_rdy;
    endfunction

    function automatic logic val_of(input bit is_b);
        return is_b ? b_val : a_val;
    endfunction

    task automatic drive(input bit is_b, input logic v, input int n);
        if (is_b) begin b_val = v; b_i = 12'(n); b_q = ~12'(n); end
        else      begin a_val = v; a_i = 12'(n); a_q = ~12'(n); end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst;
        rst = 1'b1; step(); rst = 1'b0; step();
    endtask

    // Stream one frame for a requester; optional 5-cycle val gap at sample gap_at.
    task automatic run_frame(input bit is_b, input int gap_at, input bit keep,
                             input logic [7:0] conf, input string tag);
        int n, guard;
        bit gapped, will_acc;
        n = 0; guard = 0; gapped = 0;
        drive(is_b, 1'b1, 0);
        while (rdy_of(is_b) !== 1'b1 && guard < 5000) begin step(); guard++; end
        chk({tag, "_grant"}, 32'(rdy_of(is_b)), 32'd1);
        chk({tag, "_conf"}, 32'(fft_conf), 32'(conf));
        ival_cnt = 0; dat_err = 0; conf_err = 0; mon_conf = conf;
        while (n < 1024 && guard < 10000) begin
            if (n == gap_at && !gapped) begin
                gapped = 1;
                drive(is_b, 1'b0, n);
                repeat (5) step();
                drive(is_b, 1'b1, n);
            end
            @(negedge clk);
            will_acc = val_of(is_b) && rdy_of(is_b);
            step();
            guard++;
            if (will_acc) n++;
            drive(is_b, (n < 1024) || keep, n);
        end
        chk({tag, "_accepted"}, 32'(n), 32'd1024);
        chk({tag, "_rdy_end"}, 32'(rdy_of(is_b)), 32'd0);
        step();
        chk({tag, "_ivals"}, 32'(ival_cnt), 32'd1024);
        chk({tag, "_data"}, 32'(dat_err), 32'd0);
        chk({tag, "_conf_hold"}, 32'(conf_err), 32'd0);
    endtask

    // Emit one core output frame and check its routing.
    task automatic core_out(input int len, input logic [7:0] exp, input bit to_b,
                            input logic [7:0] oexp_exp, input string tag);
        int hit, miss, eop_at, bad;
        hit = 0; miss = 0; eop_at = -1; bad = 0;
        for (int k = 0; k < len; k++) begin
            fft_oval = 1'b1; fft_oi = 12'(k + 7); fft_oq = 12'(3 * k);
            fft_oeop = (k == len - 1); fft_oexp = exp;
            #1;
            if (to_b ? ob_val : oa_val) hit++;
            if (to_b ? oa_val : ob_val) miss++;
            if (to_b ? ob_eop : oa_eop) begin
                if (eop_at < 0) eop_at = k; else bad++;
            end
            if (o_i !== fft_oi || o_q !== fft_oq || o_exp !== oexp_exp) bad++;
            step();
        end
        fft_oval = 1'b0; fft_oeop = 1'b0;
        chk({tag, "_routed"}, 32'(hit), 32'(len));
        chk({tag, "_other"}, 32'(miss), 32'd0);
        chk({tag, "_eop_pos"}, 32'(eop_at), 32'(len - 1));
        chk({tag, "_data_exp"}, 32'(bad), 32'd0);
    endtask

    task automatic orphan_pulse(input string tag);
        fft_oval = 1'b1; fft_oeop = 1'b1; fft_oi = 12'h123; fft_oexp = 8'h11;
        #1;
        chk({tag, "_no_route"}, 32'({oa_val, ob_val}), 32'd0);
        step();
        fft_oval = 1'b0; fft_oeop = 1'b0;
        chk({tag, "_err_set"}, 32'(err_orphan), 32'd1);
        repeat (3) step();
        chk({tag, "_err_sticky"}, 32'(err_orphan), 32'd1);
    endtask

    initial begin
        int rdy_seen, n, guard;
        bit will_acc;
        rst = 1'b1;
        a_val = 0; a_i = 0; a_q = 0; b_val = 0; b_i = 0; b_q = 0;
        fft_oval = 0; fft_oeop = 0; fft_oi = 0; fft_oq = 0; fft_oexp = 0;
        repeat (3) step();
        chk("rst_a_rdy", 32'(a_rdy), 32'd0);
        chk("rst_b_rdy", 32'(b_rdy), 32'd0);
        chk("rst_ival", 32'(fft_ival), 32'd0);
        chk("rst_conf", 32'(fft_conf), 32'd0);
        chk("rst_err", 32'(err_orphan), 32'd0);
        rst = 1'b0;
        step();

        orphan_pulse("orphan0");
        pulse_rst();
        chk("err_cleared", 32'(err_orphan), 32'd0);

        // A alone with a 5-cycle gap mid-frame, then its output frame.
        run_frame(1'b0, 500, 1'b0, CONF_A, "a_gap");
        core_out(1024, 8'd3, 1'b0, 8'd3, "out_a0");

        // Fresh round-robin state: simultaneous requests alternate A, B, A, B.
        pulse_rst();
        drive(1'b0, 1'b1, 0);
        drive(1'b1, 1'b1, 0);
        run_frame(1'b0, -1, 1'b1, CONF_A, "tie1_a");
        run_frame(1'b1, -1, 1'b1, CONF_B, "tie2_b");
        run_frame(1'b0, -1, 1'b1, CONF_A, "tie3_a");
        run_frame(1'b1, -1, 1'b1, CONF_B, "tie4_b");

        // Four tags in flight: no grant while both still request.
        rdy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_rdy || b_rdy) rdy_seen++;
            step();
        end
        chk("full_no_rdy", 32'(rdy_seen), 32'd0);
        chk("full_conf_held", 32'(fft_conf), 32'(CONF_B));

        // One output frame frees a slot; A (not served last) gets it.
        core_out(8, 8'd3, 1'b0, 8'd3, "out_a1");
        run_frame(1'b0, -1, 1'b0, CONF_A, "after_pop_a");
        drive(1'b1, 1'b0, 0);

`ifdef XCORR_EXP_ACC_EN
        core_out(8, 8'd4, 1'b1, 8'd7, "out_b1");
        core_out(8, 8'hF0, 1'b0, 8'hF0, "out_a2");
        core_out(8, 8'h20, 1'b1, 8'hFF, "out_b2");
`else
        core_out(8, 8'd4, 1'b1, 8'd4, "out_b1");
        core_out(8, 8'hF0, 1'b0, 8'hF0, "out_a2");
        core_out(8, 8'h20, 1'b1, 8'h20, "out_b2");
`endif
        core_out(8, 8'd1, 1'b0, 8'd1, "out_a3");

        // Reset in the middle of an A frame after 500 samples.
        drive(1'b0, 1'b1, 0);
        n = 0; guard = 0;
        while (n < 500 && guard < 3000) begin
            @(negedge clk);
            will_acc = a_val && a_rdy;
            step();
            guard++;
            if (will_acc) n++;
            drive(1'b0, 1'b1, n);
        end
        chk("mid_accepted", 32'(n), 32'd500);
        rst = 1'b1;
        step();
        chk("mid_rst_a_rdy", 32'(a_rdy), 32'd0);
        chk("mid_rst_ival", 32'(fft_ival), 32'd0);
        chk("mid_rst_conf", 32'(fft_conf), 32'd0);
        chk("mid_rst_fft_i", 32'(fft_i), 32'd0);
        chk("mid_rst_err", 32'(err_orphan), 32'd0);
        drive(1'b0, 1'b0, 0);
        rst = 1'b0;
        step();
        // The abandoned frame's tag must be gone.
        orphan_pulse("orphan_after_rst");
        pulse_rst();
        // Counter restarted from zero: a full 1024-sample frame follows.
        run_frame(1'b0, -1, 1'b0, CONF_A, "post_rst_a");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
